// File: rtl/ifetch.sv
// ifetch: instruction fetch stage with an in-order fetch queue feeding decode.
// Optional build macro IFETCH_PREFETCH_EN selects a 2-entry queue, which sustains
// one instruction per cycle. Without it, the queue has 1 entry and fetch
// alternates with consume.
module ifetch #(
   parameter logic [31:0] RESET_PC = 32'h00000000
) (
   input  logic        CLK,
   input  logic        RES,
   input  logic        HLT,
   input  logic        JREQ,
   input  logic [31:0] JADDR,
   output logic        IREQ,
   output logic [31:0] IADDR,
   input  logic        IACK,
   input  logic [31:0] IDATAIN,
   output logic [31:0] IDATA,
   output logic [31:0] PC,
   output logic        FLUSH,
   output logic        XRES
);

`ifdef IFETCH_PREFETCH_EN
   localparam int unsigned DEPTH = 2;
`else
   localparam int unsigned DEPTH = 1;
`endif
   localparam int unsigned XLEN  = 32;
   localparam int unsigned CNT_W = 2;
   localparam logic [XLEN-1:0] NOP = 32'h00000013;

   logic [XLEN-1:0]  addr_q, addr_d;
   logic [XLEN-1:0]  last_pc_q, last_pc_d;
   logic [CNT_W-1:0] count_q, count_d;
   logic [XLEN-1:0]  h_pc_q, h_pc_d;
   logic [XLEN-1:0]  h_ins_q, h_ins_d;
`ifdef IFETCH_PREFETCH_EN
   logic [XLEN-1:0]  t_pc_q, t_pc_d;
   logic [XLEN-1:0]  t_ins_q, t_ins_d;
`endif
   logic             xres_q;

   logic             empty;
   logic             fill;
   logic             pop;
   logic [XLEN-1:0]  jtarget;
   logic             unused_jaddr_lsb;

   assign jtarget          = {JADDR[31:2], 2'b00};
   assign unused_jaddr_lsb = ^JADDR[1:0];

   // Handshake and queue movement for this cycle
   assign empty = (count_q == CNT_W'(0));
   assign IREQ  = !RES && !JREQ && (count_q < CNT_W'(DEPTH));
   assign fill  = IREQ && IACK;
   assign pop   = !HLT && !empty && !JREQ;

   // Decode-side view: head of queue, or a NOP bubble holding the last PC
   assign IADDR = addr_q;
   assign FLUSH = RES || empty;
   assign IDATA = (RES || empty) ? NOP : h_ins_q;
   assign PC    = empty ? last_pc_q : h_pc_q;
   assign XRES  = xres_q;

   // Next-state: redirect wins over pop/fill; otherwise shift head and append at tail
   always_comb begin
      addr_d    = addr_q;
      last_pc_d = last_pc_q;
      count_d   = count_q;
      h_pc_d    = h_pc_q;
      h_ins_d   = h_ins_q;
`ifdef IFETCH_PREFETCH_EN
      t_pc_d    = t_pc_q;
      t_ins_d   = t_ins_q;
`endif
      if (JREQ) begin
         addr_d    = jtarget;
         last_pc_d = jtarget;
         count_d   = CNT_W'(0);
      end else begin
         if (!empty) begin
            last_pc_d = h_pc_q;
         end
         if (fill) begin
            addr_d = addr_q + 32'd4;
         end
         count_d = count_q + CNT_W'(fill) - CNT_W'(pop);
         if (pop) begin
`ifdef IFETCH_PREFETCH_EN
            if (count_q == CNT_W'(2)) begin
               h_pc_d  = t_pc_q;
               h_ins_d = t_ins_q;
            end else
`endif
            if (fill) begin
               h_pc_d  = addr_q;
               h_ins_d = IDATAIN;
            end
         end else if (fill && empty) begin
            h_pc_d  = addr_q;
            h_ins_d = IDATAIN;
         end
`ifdef IFETCH_PREFETCH_EN
         // A new word lands behind the head; with count==1 and a pop it became the head above
         if (fill && (count_q == CNT_W'(1)) && !pop) begin
            t_pc_d  = addr_q;
            t_ins_d = IDATAIN;
         end
`endif
      end
   end

   // Control state: synchronous reset restarts fetch at RESET_PC with an empty queue
   always_ff @(posedge CLK) begin
      if (RES) begin
         addr_q    <= RESET_PC;
         last_pc_q <= RESET_PC;
         count_q   <= CNT_W'(0);
      end else begin
         addr_q    <= addr_d;
         last_pc_q <= last_pc_d;
         count_q   <= count_d;
      end
   end

   // Queue payload; only meaningful where count marks it occupied
   always_ff @(posedge CLK) begin
      h_pc_q  <= h_pc_d;
      h_ins_q <= h_ins_d;
`ifdef IFETCH_PREFETCH_EN
      t_pc_q  <= t_pc_d;
      t_ins_q <= t_ins_d;
`endif
   end

   // Reset indication to decode, delayed one cycle
   always_ff @(posedge CLK) begin
      xres_q <= RES;
   end

endmodule
